// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: stall bus, canned stall patterns
// and the redirect FSM encoding.
package pipe_ctrl_pkg;

    typedef logic [5:0] stall_bus_t;

    // Bit i holds stage i: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_IF   = 6'b000011;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_MEM  = 6'b011111;
    localparam stall_bus_t STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        CTRL_RUN,
        CTRL_PEND,
        CTRL_FLUSH
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall sources, turns EX mispredicts into flushes
// plus a PC redirect (held across MEM stalls), and counts stalls/redirects.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             if_stall_req,
    input  logic             mem_stall_req,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic [4:0]       id_raddr1,
    input  logic [4:0]       id_raddr2,
    input  logic             ex_load,
    input  logic [4:0]       ex_waddr,
    input  logic             ex_mispredict,
    input  logic [31:0]      ex_redirect_pc,
    output logic [5:0]       stall,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int FC_W = $clog2(FLUSH_CYCLES) + 1;

    ctrl_state_e     state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic [31:0]     pend_pc_q, pend_pc_d;
    logic [31:0]     last_pc_q;
    logic            load_use, mis, accept;
    logic [31:0]     tgt;
    stall_bus_t      stall_b;

    assign load_use = ex_load && (ex_waddr != 5'd0) &&
                      ((id_re1 && (id_raddr1 == ex_waddr)) ||
                       (id_re2 && (id_raddr2 == ex_waddr)));

    // In FLUSH the EX stage holds only bubbles, so its mispredict is ignored.
    assign mis    = ((state_q == CTRL_RUN) && ex_mispredict) || (state_q == CTRL_PEND);
    assign tgt    = (state_q == CTRL_PEND) ? pend_pc_q : ex_redirect_pc;
    assign accept = rst_n && rdy && !mem_stall_req && mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CTRL_RUN;
            fcnt_q    <= '0;
            pend_pc_q <= '0;
            last_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            pend_pc_q <= pend_pc_d;
            if (accept)
                last_pc_q <= tgt;
        end
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        pend_pc_d = pend_pc_q;
        if (accept) begin
            state_d = (FLUSH_CYCLES == 1) ? CTRL_RUN : CTRL_FLUSH;
            fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
        end else if (rdy && mem_stall_req) begin
            if ((state_q == CTRL_RUN) && ex_mispredict) begin
                state_d   = CTRL_PEND;
                pend_pc_d = ex_redirect_pc;
            end
        end else if (rdy && (state_q == CTRL_FLUSH)) begin
            fcnt_d = fcnt_q - FC_W'(1);
            if (fcnt_q == FC_W'(1))
                state_d = CTRL_RUN;
        end
    end

    // Outputs are combinational, so they are forced quiet while reset is held.
    always_comb begin
        stall_b        = STALL_NONE;
        flush_ifid     = 1'b0;
        flush_idex     = 1'b0;
        redirect_valid = 1'b0;
        if (!rst_n) begin
            stall_b = STALL_NONE;
        end else if (!rdy) begin
            stall_b = STALL_ALL;
        end else if (mem_stall_req) begin
            stall_b = STALL_MEM;
        end else if (mis) begin
            flush_ifid     = 1'b1;
            flush_idex     = 1'b1;
            redirect_valid = 1'b1;
        end else begin
            if (load_use)
                stall_b = STALL_ID;
            else if (if_stall_req)
                stall_b = STALL_IF;
            flush_ifid = (state_q == CTRL_FLUSH);
        end
    end

    assign stall       = stall_b;
    assign redirect_pc = redirect_valid ? tgt : last_pc_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rdy && stall_b[0]),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect_valid),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a random run,
// all judged against a cycle-level behavioural model of the sequencing rules.
module tb_pipe_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n, rdy, if_stall_req, mem_stall_req;
    logic        id_re1, id_re2, ex_load, ex_mispredict;
    logic [4:0]  id_raddr1, id_raddr2, ex_waddr;
    logic [31:0] ex_redirect_pc;

    logic [5:0]  stall, s_stall;
    logic        flush_ifid, flush_idex, redirect_valid;
    logic        s_flush_ifid, s_flush_idex, s_redirect_valid;
    logic [31:0] redirect_pc, s_redirect_pc, stall_cnt, flush_cnt;
    logic [2:0]  s_stall_cnt, s_flush_cnt;
    logic [40:0] obs, exp_o;

    int n_run = 0;
    int n_fail = 0;

    // Model state: pending redirect, remaining flush cycles, last target, counters.
    bit          m_pend;
    logic [31:0] m_pend_pc, m_last_pc;
    int          m_flush_left;
    longint      m_stall_cnt, m_flush_cnt;
    int          m_s3_stall, m_s3_flush;

    always #5 clk = ~clk;

    assign obs = {stall, flush_ifid, flush_idex, redirect_valid, redirect_pc};

    pipe_ctrl #(.CNT_W(32), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .if_stall_req(if_stall_req),
        .mem_stall_req(mem_stall_req), .id_re1(id_re1), .id_re2(id_re2),
        .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .ex_load(ex_load),
        .ex_waddr(ex_waddr), .ex_mispredict(ex_mispredict),
        .ex_redirect_pc(ex_redirect_pc), .stall(stall), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.CNT_W(3), .FLUSH_CYCLES(FC)) dut_sat (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .if_stall_req(if_stall_req),
        .mem_stall_req(mem_stall_req), .id_re1(id_re1), .id_re2(id_re2),
        .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .ex_load(ex_load),
        .ex_waddr(ex_waddr), .ex_mispredict(ex_mispredict),
        .ex_redirect_pc(ex_redirect_pc), .stall(s_stall), .flush_ifid(s_flush_ifid),
        .flush_idex(s_flush_idex), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Expected {stall, flush_ifid, flush_idex, redirect_valid, redirect_pc}.
    function automatic logic [40:0] model_eval();
        logic [5:0]  s;
        logic        fi, fe, rv, lu, mis;
        logic [31:0] pc;
        s = 6'd0; fi = 1'b0; fe = 1'b0; rv = 1'b0; pc = m_last_pc;
        lu = ex_load && (ex_waddr != 0) &&
             ((id_re1 && id_raddr1 == ex_waddr) || (id_re2 && id_raddr2 == ex_waddr));
        mis = m_pend || (ex_mispredict && m_flush_left == 0);
        if (!rst_n) pc = 32'd0;
        else if (!rdy) s = 6'b111111;
        else if (mem_stall_req) s = 6'b011111;
        else if (mis) begin
            fi = 1'b1; fe = 1'b1; rv = 1'b1;
            pc = m_pend ? m_pend_pc : ex_redirect_pc;
        end else begin
            s  = lu ? 6'b000111 : (if_stall_req ? 6'b000011 : 6'b000000);
            fi = (m_flush_left > 0);
        end
        return {s, fi, fe, rv, pc};
    endfunction

    task automatic model_reset();
        m_pend = 0; m_pend_pc = 0; m_last_pc = 0; m_flush_left = 0;
        m_stall_cnt = 0; m_flush_cnt = 0; m_s3_stall = 0; m_s3_flush = 0;
    endtask

    // Advance one clock, updating the model from the values seen at the edge.
    task automatic tick();
        logic [40:0] e;
        e = model_eval();
        @(posedge clk);
        if (rst_n && rdy) begin
            if (e[35]) begin
                if (m_stall_cnt != 64'hFFFF_FFFF) m_stall_cnt++;
                if (m_s3_stall != 7) m_s3_stall++;
            end
            if (e[32]) begin
                if (m_flush_cnt != 64'hFFFF_FFFF) m_flush_cnt++;
                if (m_s3_flush != 7) m_s3_flush++;
                m_last_pc    = e[31:0];
                m_pend       = 0;
                m_flush_left = FC - 1;
            end else if (mem_stall_req) begin
                if (!m_pend && m_flush_left == 0 && ex_mispredict) begin
                    m_pend    = 1;
                    m_pend_pc = ex_redirect_pc;
                end
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end
        end
        #1;
    endtask

    task automatic quiet();
        if_stall_req = 0; mem_stall_req = 0; id_re1 = 0; id_re2 = 0;
        id_raddr1 = 0; id_raddr2 = 0; ex_load = 0; ex_waddr = 0;
        ex_mispredict = 0; ex_redirect_pc = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; rdy = 1; quiet(); model_reset();
        #1;
        n_run++;
        if ({obs, stall_cnt, flush_cnt} !== 105'd0) begin
            n_fail++; $display("FAIL reset_state obs=%h cnt=%0d/%0d required all zero", obs, stall_cnt, flush_cnt);
        end
        @(posedge clk); #1 rst_n = 1; #1;
        exp_o = model_eval();
        n_run++;
        if (obs !== exp_o) begin n_fail++; $display("FAIL reset_release obs=%h required %h", obs, exp_o); end
    endtask

    task automatic test_load_use();
        ex_load = 1; ex_waddr = 5; id_re2 = 1; id_raddr2 = 5; #1;
        exp_o = model_eval();
        n_run++;
        if (obs !== exp_o || stall !== 6'b000111) begin
            n_fail++; $display("FAIL load_use_hit obs=%h required %h", obs, exp_o);
        end
        tick();
        ex_waddr = 0; id_raddr2 = 0; #1;
        exp_o = model_eval();
        n_run++;
        if (obs !== exp_o || stall !== 6'b000000) begin
            n_fail++; $display("FAIL load_use_x0 obs=%h required %h", obs, exp_o);
        end
        tick(); quiet();
    endtask

    task automatic test_mispredict();
        ex_mispredict = 1; ex_redirect_pc = 32'h1040; #1;
        exp_o = model_eval();
        n_run++;
        if (obs !== exp_o || {flush_ifid, flush_idex, redirect_valid, redirect_pc} !== {3'b111, 32'h1040}) begin
            n_fail++; $display("FAIL mispred_accept obs=%h required %h", obs, exp_o);
        end
        tick(); ex_mispredict = 0; #1;
        exp_o = model_eval();
        n_run++;
        if (obs !== exp_o || {flush_ifid, flush_idex, redirect_valid} !== 3'b100) begin
            n_fail++; $display("FAIL mispred_flush2 obs=%h required %h", obs, exp_o);
        end
        tick(); #1;
        exp_o = model_eval();
        n_run++;
        if (obs !== exp_o || flush_ifid !== 1'b0 || flush_cnt !== m_flush_cnt[31:0]) begin
            n_fail++; $display("FAIL mispred_idle obs=%h cnt=%0d required %h cnt=%0d", obs, flush_cnt, exp_o, m_flush_cnt);
        end
        quiet();
    endtask

    task automatic test_held_redirect();
        mem_stall_req = 1; ex_mispredict = 1; ex_redirect_pc = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp_o = model_eval();
            n_run++;
            if (obs !== exp_o || stall !== 6'b011111 || redirect_valid !== 1'b0) begin
                n_fail++; $display("FAIL held_stall%0d obs=%h required %h", i, obs, exp_o);
            end
            tick(); ex_mispredict = 0; ex_redirect_pc = 32'h3333;
        end
        mem_stall_req = 0; #1;
        exp_o = model_eval();
        n_run++;
        if (obs !== exp_o || redirect_pc !== 32'h2000 || {flush_ifid, flush_idex, redirect_valid} !== 3'b111) begin
            n_fail++; $display("FAIL held_fire obs=%h required %h", obs, exp_o);
        end
        tick(); tick(); quiet();
    endtask

    task automatic test_simultaneous();
        ex_mispredict = 1; ex_redirect_pc = 32'h4444; if_stall_req = 1;
        ex_load = 1; ex_waddr = 7; id_re1 = 1; id_raddr1 = 7; #1;
        exp_o = model_eval();
        n_run++;
        if (obs !== exp_o || stall !== 6'd0 || redirect_valid !== 1'b1) begin
            n_fail++; $display("FAIL simultaneous obs=%h required %h", obs, exp_o);
        end
        quiet(); tick(); tick();
    endtask

    task automatic test_freeze();
        ex_mispredict = 1; ex_redirect_pc = 32'h5550; tick(); quiet();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp_o = model_eval();
            n_run++;
            if (obs !== exp_o || stall !== 6'b111111 || stall_cnt !== m_stall_cnt[31:0] ||
                flush_cnt !== m_flush_cnt[31:0]) begin
                n_fail++; $display("FAIL freeze%0d obs=%h cnt=%0d/%0d required %h cnt=%0d/%0d",
                                   i, obs, stall_cnt, flush_cnt, exp_o, m_stall_cnt, m_flush_cnt);
            end
            tick();
        end
        rdy = 1; #1;
        exp_o = model_eval();
        n_run++;
        if (obs !== exp_o || flush_ifid !== 1'b1) begin
            n_fail++; $display("FAIL freeze_resume obs=%h required %h", obs, exp_o);
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid_flush();
        ex_mispredict = 1; ex_redirect_pc = 32'h6660; tick(); quiet();
        rst_n = 0; model_reset(); if_stall_req = 1; ex_mispredict = 1; #1;
        n_run++;
        if ({obs, stall_cnt, flush_cnt} !== 105'd0) begin
            n_fail++; $display("FAIL reset_mid_flush obs=%h cnt=%0d/%0d required all zero", obs, stall_cnt, flush_cnt);
        end
        tick(); quiet(); rst_n = 1; #1;
        exp_o = model_eval();
        n_run++;
        if (obs !== exp_o || flush_ifid !== 1'b0) begin
            n_fail++; $display("FAIL reset_to_run obs=%h required %h", obs, exp_o);
        end
    endtask

    task automatic test_saturation();
        if_stall_req = 1;
        for (int i = 0; i < 10; i++) tick();
        n_run++;
        if (s_stall_cnt !== 3'(m_s3_stall) || s_stall_cnt !== 3'd7 || stall_cnt !== m_stall_cnt[31:0]) begin
            n_fail++; $display("FAIL saturation sat=%0d wide=%0d required 7 and %0d", s_stall_cnt, stall_cnt, m_stall_cnt);
        end
        tick();
        n_run++;
        if (s_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_hold sat=%0d required 7", s_stall_cnt); end
        quiet();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rdy            = ($urandom_range(0, 7) != 0);
            if_stall_req   = ($urandom_range(0, 3) == 0);
            mem_stall_req  = ($urandom_range(0, 3) == 0);
            ex_mispredict  = ($urandom_range(0, 5) == 0);
            ex_redirect_pc = $urandom;
            ex_load        = $urandom_range(0, 1);
            ex_waddr       = 5'($urandom_range(0, 3));
            id_re1         = $urandom_range(0, 1);
            id_re2         = $urandom_range(0, 1);
            id_raddr1      = 5'($urandom_range(0, 3));
            id_raddr2      = 5'($urandom_range(0, 3));
            #1;
            exp_o = model_eval();
            n_run++;
            if (obs !== exp_o || stall_cnt !== m_stall_cnt[31:0] || flush_cnt !== m_flush_cnt[31:0] ||
                s_stall_cnt !== 3'(m_s3_stall) || s_flush_cnt !== 3'(m_s3_flush)) begin
                n_fail++;
                $display("FAIL random%0d obs=%h cnt=%0d/%0d sat=%0d/%0d required %h cnt=%0d/%0d sat=%0d/%0d",
                         i, obs, stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt,
                         exp_o, m_stall_cnt, m_flush_cnt, m_s3_stall, m_s3_flush);
            end
            tick();
        end
        quiet(); rdy = 1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mispredict();
        test_held_redirect();
        test_simultaneous();
        test_freeze();
        test_reset_mid_flush();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
